// File: rtl/pipe_reg_skid.sv
// Two-entry pipeline register with skid buffer: full throughput, registered in_ready.
// Optional performance counters enabled by defining PIPE_REG_SKID_PERF_EN.
module pipe_reg_skid #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_REG_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_xfer_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              in_fire, out_fire;

  if (DATA_W < 1 || DATA_W > 256 || CNT_W < 1) begin : g_bad_params
    $error("pipe_reg_skid: illegal DATA_W/CNT_W");
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // Vacated entries are cleared so idle outputs and the unused skid read zero.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            state_next = TWO;
            skid_next  = in_data;
          end else if (out_fire) begin
            state_next = EMPTY;
            main_next  = '0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_next = ONE;
            main_next  = skid_reg;
            skid_next  = '0;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = '0;
          skid_next  = '0;
        end
      endcase
    end
  end

  // in_ready depends only on registered state, breaking the out_ready path.
  always_comb begin
    in_ready  = (state_reg == EMPTY) || (state_reg == ONE);
    out_valid = (state_reg == ONE) || (state_reg == TWO);
    out_data  = out_valid ? main_reg : '0;
    occupancy = state_reg;
  end

`ifdef PIPE_REG_SKID_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_xfer_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (out_fire) begin
        perf_xfer_cnt <= perf_xfer_cnt + CNT_W'(1);
      end
      if (out_valid && !out_ready) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed and randomized checks of pipe_reg_skid against a queue scoreboard.
module tb_pipe_reg_skid;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_REG_SKID_PERF_EN
  logic [CNT_W-1:0]  perf_xfer_cnt;
  logic [CNT_W-1:0]  perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_reg_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_REG_SKID_PERF_EN
    ,
    .perf_xfer_cnt  (perf_xfer_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ir, input logic ov,
                            input logic [DATA_W-1:0] od, input logic [1:0] occ);
    check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_data"},  32'(out_data),  32'(od));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    $display("step %s: in_ready=%0b out_valid=%0b out_data=%0h occupancy=%0d",
             tag, in_ready, out_valid, out_data, occupancy);
  endtask

  initial begin
    // Reset
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check_outs("reset", 1'b1, 1'b0, '0, 2'd0);
`ifdef PIPE_REG_SKID_PERF_EN
    check("reset.xfer",  32'(perf_xfer_cnt),  32'd0);
    check("reset.stall", 32'(perf_stall_cnt), 32'd0);
`endif

    // Single transfer, one-cycle latency
    in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1; tick();
    check_outs("single", 1'b1, 1'b1, 16'h00A5, 2'd1);
    in_valid = 1'b0; tick();
    check_outs("single_drain", 1'b1, 1'b0, '0, 2'd0);

    // Fill to two entries under backpressure, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0001; tick();
    check_outs("fill1", 1'b1, 1'b1, 16'h0001, 2'd1);
    in_data = 16'h0002; tick();
    check_outs("fill2", 1'b0, 1'b1, 16'h0001, 2'd2);
    in_data = 16'h0003; tick();
    check_outs("held3", 1'b0, 1'b1, 16'h0001, 2'd2);
    out_ready = 1'b1; tick();
    check_outs("drain2", 1'b1, 1'b1, 16'h0002, 2'd1);
    tick();
    check_outs("drain3", 1'b1, 1'b1, 16'h0003, 2'd1);
    in_valid = 1'b0; tick();
    check_outs("drained", 1'b1, 1'b0, '0, 2'd0);

    // Flush while full, with in_valid asserted
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h0010; tick();
    in_data = 16'h0020; tick();
    check_outs("full_pre_flush", 1'b0, 1'b1, 16'h0010, 2'd2);
    flush = 1'b1; in_data = 16'h0030; tick();
    flush = 1'b0; in_valid = 1'b0;
    check_outs("flush_full", 1'b1, 1'b0, '0, 2'd0);

    // Flush in ONE with simultaneous in/out handshakes discards the payload
    in_valid = 1'b1; in_data = 16'h0040; tick();
    flush = 1'b1; in_data = 16'h0050; out_ready = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check_outs("flush_one", 1'b1, 1'b0, '0, 2'd0);

    // Reset beats flush while full
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h0061; tick();
    in_data = 16'h0062; tick();
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_outs("rst_flush", 1'b1, 1'b0, '0, 2'd0);
`ifdef PIPE_REG_SKID_PERF_EN
    check("rst_flush.xfer",  32'(perf_xfer_cnt),  32'd0);
    check("rst_flush.stall", 32'(perf_stall_cnt), 32'd0);

    // 5 transfers then 3 stall cycles
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = DATA_W'(k + 1); tick();
    end
    in_valid = 1'b0; tick();
    in_valid = 1'b1; out_ready = 1'b0; in_data = 16'h0077; tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("perf5.xfer",  32'(perf_xfer_cnt),  32'd5);
    check("perf5.stall", 32'(perf_stall_cnt), 32'd3);
    $display("step perf5: xfer=%0d stall=%0d", perf_xfer_cnt, perf_stall_cnt);
    // Flush does not clear counters; this cycle is itself a stall
    flush = 1'b1; tick(); flush = 1'b0;
    check("perf_flush.xfer",  32'(perf_xfer_cnt),  32'd5);
    check("perf_flush.stall", 32'(perf_stall_cnt), 32'd4);

    // 17 transfers wrap a 4-bit counter to 1
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_data = DATA_W'(k + 16'h100); tick();
    end
    in_valid = 1'b0; tick();
    check("perf17.xfer",  32'(perf_xfer_cnt),  32'd1);
    check("perf17.stall", 32'(perf_stall_cnt), 32'd0);
    $display("step perf17: xfer=%0d stall=%0d", perf_xfer_cnt, perf_stall_cnt);
`endif

    // Randomized traffic against the queue scoreboard
    rst = 1'b1; tick(); rst = 1'b0;
    sb_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic exp_in_ready, exp_out_valid, do_in, do_out;
      logic [DATA_W-1:0] exp_data;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = DATA_W'($urandom);
      #1;
      exp_in_ready  = (sb_q.size() < 2);
      exp_out_valid = (sb_q.size() > 0);
      exp_data      = exp_out_valid ? sb_q[0] : '0;
      check("rnd.in_ready",  32'(in_ready),  32'(exp_in_ready));
      check("rnd.out_valid", 32'(out_valid), 32'(exp_out_valid));
      check("rnd.out_data",  32'(out_data),  32'(exp_data));
      check("rnd.occupancy", 32'(occupancy), 32'(sb_q.size()));
      if (occupancy == 2'd2 && in_ready) begin
        check("rnd.ready_when_full", 32'(in_ready), 32'd0);
      end
      do_in  = in_valid && exp_in_ready;
      do_out = exp_out_valid && out_ready;
      if (flush) begin
        sb_q.delete();
      end else begin
        if (do_out) void'(sb_q.pop_front());
        if (do_in) sb_q.push_back(in_data);
      end
      tick();
      if (n_err > 50) break;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    $display("step random: done, scoreboard depth %0d", sb_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, payload width in bits (legal 1..256).
REQ-002 SHALL provide parameter CNT_W, default 32, perf counter width (used only under REQ-030).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port flush  input  1  discard all held entries (pipeline bubble).
REQ-006 SHALL provide port in_valid  input  1  upstream payload valid.
REQ-007 SHALL provide port in_ready  output  1  block can accept payload this cycle.
REQ-008 SHALL provide port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL provide port out_valid  output  1  out_data valid.
REQ-010 SHALL provide port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL provide port out_data  output  DATA_W  head-of-stage payload.
REQ-012 SHALL provide port occupancy  output  2  entries held (0, 1 or 2).

Function
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 SHALL hold a main entry and a skid entry; states EMPTY (0), ONE (main valid), TWO (main+skid valid).
REQ-015 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO, from registered state only (no combinational path out_ready -> in_ready).
REQ-016 SHALL drive out_valid = 1 in ONE and TWO; out_data = main entry; occupancy = state count.
REQ-017 EMPTY: in_fire -> ONE, main <= in_data; else stay.
REQ-018 ONE: in_fire & out_fire -> ONE, main <= in_data; in_fire & !out_fire -> TWO, skid <= in_data; !in_fire & out_fire -> EMPTY, main <= 0; neither -> hold.
REQ-019 TWO: out_fire -> ONE, main <= skid, skid <= 0; else hold (no in_fire possible).
REQ-020 SHALL preserve order strictly; no payload dropped or duplicated except by flush/rst.
REQ-021 SHALL give 1-cycle latency in_fire -> out_valid, and sustain 1 transfer/cycle while out_ready=1.
REQ-022 SHALL drive out_data = 0 whenever out_valid = 0; unused skid entry SHALL read 0.
REQ-023 flush=1 SHALL, next cycle, set state EMPTY, zero both entries; any in_fire and out_fire in the flush cycle are still counted as handshakes but the accepted payload is discarded.
REQ-024 flush SHALL take priority over every REQ-017..019 transition.
REQ-025 Payload SHALL be stored verbatim; no width conversion or arithmetic on data.

Reset
REQ-026 rst=1 at a clock edge SHALL set state EMPTY, both entries 0, irrespective of flush/in_valid/out_ready.
REQ-027 After reset: in_ready=1, out_valid=0, out_data=0, occupancy=0.
REQ-028 rst SHALL take priority over flush; reset mid-transfer SHALL discard held payloads.
REQ-029 rst SHALL also clear perf counters (REQ-030); flush SHALL NOT.

Configuration
REQ-030 With macro PIPE_REG_SKID_PERF_EN defined: outputs perf_xfer_cnt (CNT_W, +1 per out_fire) and perf_stall_cnt (CNT_W, +1 per cycle with out_valid & !out_ready), both wrapping modulo 2^CNT_W.
REQ-031 Without PIPE_REG_SKID_PERF_EN: counter ports and logic absent; all other behaviour identical.

Verification
REQ-032 rst then in_valid=1, in_data=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, occupancy=1, in_ready=1.
REQ-033 Stream 0x1,0x2,0x3 with out_ready=0 -> after 2 accepts occupancy=2, in_ready=0, 0x3 held upstream; out_ready=1 -> outputs 0x1,0x2,0x3 in order, one per cycle.
REQ-034 occupancy=2 (0x10,0x20), flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1.
REQ-035 occupancy=2, rst=1 and flush=1 together -> all outputs at reset values; perf counters 0.
REQ-036 PERF_EN: 5 transfers then 3 cycles out_valid=1, out_ready=0 -> perf_xfer_cnt=5, perf_stall_cnt=3; CNT_W=4, 17 transfers -> perf_xfer_cnt=1.
REQ-037 Random in_valid/out_ready 10k cycles vs scoreboard -> no loss, duplication or reordering; in_ready never 1 when occupancy=2.
